decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 215 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// In-order decode/issue stage for an RV32I pipeline. It classifies the
// instruction offered by fetch and reads its sources from the register file.
// A 32-entry scoreboard holds back any instruction that reads or overwrites a
// register that an older, still-pending instruction will write. Accepted
// instructions go into a single-entry output register towards execute.
//
// Configuration macro: WB_BYPASS_EN
//   defined   : a same-cycle writeback to a source register supplies that
//               source's value and lifts the stall on that source.
//   undefined : no bypass. The stage stalls until the busy bit clears, and
//               the value is then read from op1/op2.
//
// Ports
//   clk                 sole clock; all state updates on the rising edge
//   rst                 synchronous, active-high reset
//   if_valid/if_ready   fetch handshake; an instruction is captured when
//                       both are high
//   if_instr/if_pc      offered instruction word and its PC
//   rs1/rs2             register-file read addresses (combinational)
//   op1/op2             register-file combinational read data
//   wb_en/wb_rd/wb_data writeback request; clears the scoreboard entry
//   flush               discards the held instruction
//   ex_valid/ex_ready   execute handshake
//   ex_pc/ex_instr      PC and instruction word of the held instruction
//   ex_op1/ex_op2       resolved source values (0 for unused sources)
//   ex_rd/ex_rd_wen     destination index and its write enable
// ---------------------------------------------------------------------------
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [4:0]  ex_rd,
  output logic        ex_rd_wen
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

`ifdef WB_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  logic [31:0] r_busy;
  logic        r_ex_valid;
  logic [31:0] r_ex_pc;
  logic [31:0] r_ex_instr;
  logic [31:0] r_ex_op1;
  logic [31:0] r_ex_op2;
  logic [4:0]  r_ex_rd;
  logic        r_ex_rd_wen;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic        w_use1;
  logic        w_use2;
  logic        w_writes;
  logic        w_rd_wen;
  logic        w_byp1;
  logic        w_byp2;
  logic        w_haz1;
  logic        w_haz2;
  logic        w_waw;
  logic        w_hazard;
  logic        w_capture;
  logic [31:0] w_src1;
  logic [31:0] w_src2;
  logic [31:0] w_clr_wb;
  logic [31:0] w_clr_flush;
  logic [31:0] w_set;
  logic [31:0] w_busy_nxt;

  assign w_opcode = if_instr[6:0];
  assign w_rd     = if_instr[11:7];
  assign w_rs1    = if_instr[19:15];
  assign w_rs2    = if_instr[24:20];
  assign rs1      = w_rs1;
  assign rs2      = w_rs2;

  // Opcode class: which source fields are real and whether rd is written.
  always_comb begin
    w_use1   = 1'b0;
    w_use2   = 1'b0;
    w_writes = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_use1   = 1'b1;
        w_use2   = 1'b1;
        w_writes = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        w_use1   = 1'b1;
        w_writes = 1'b1;
      end
      OPC_STORE, OPC_BRANCH: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
      end
      OPC_JAL, OPC_LUI, OPC_AUIPC: begin
        w_writes = 1'b1;
      end
      default: begin
        w_use1   = 1'b0;
        w_use2   = 1'b0;
        w_writes = 1'b0;
      end
    endcase
  end

  // x0 is hard-wired: it is never written, never busy, and always reads as 0.
  assign w_rd_wen = w_writes && (w_rd != 5'd0);

  // With bypass compiled out, BYPASS_EN is constant 0 and these collapse.
  assign w_byp1 = BYPASS_EN && wb_en && (wb_rd == w_rs1) && (w_rs1 != 5'd0);
  assign w_byp2 = BYPASS_EN && wb_en && (wb_rd == w_rs2) && (w_rs2 != 5'd0);

  assign w_src1 = (!w_use1 || (w_rs1 == 5'd0)) ? 32'd0 : (w_byp1 ? wb_data : op1);
  assign w_src2 = (!w_use2 || (w_rs2 == 5'd0)) ? 32'd0 : (w_byp2 ? wb_data : op2);

  // RAW on each used source, plus WAW on the destination. Because of the
  // WAW stall, each register has at most one pending writer.
  assign w_haz1   = w_use1 && (w_rs1 != 5'd0) && r_busy[w_rs1] && !w_byp1;
  assign w_haz2   = w_use2 && (w_rs2 != 5'd0) && r_busy[w_rs2] && !w_byp2;
  assign w_waw    = w_rd_wen && r_busy[w_rd];
  assign w_hazard = w_haz1 || w_haz2 || w_waw;

  assign if_ready  = (!r_ex_valid || ex_ready) && !w_hazard && !flush && !rst;
  assign w_capture = if_valid && if_ready;

  // Clears are applied first and the set afterwards, so a capture wins over a
  // same-cycle writeback to the same index.
  assign w_clr_wb    = (wb_en && (wb_rd != 5'd0)) ? (32'd1 << wb_rd) : 32'd0;
  assign w_clr_flush = (flush && r_ex_valid && r_ex_rd_wen) ? (32'd1 << r_ex_rd) : 32'd0;
  assign w_set       = (w_capture && w_rd_wen) ? (32'd1 << w_rd) : 32'd0;
  assign w_busy_nxt  = (r_busy & ~w_clr_wb & ~w_clr_flush) | w_set;

  // Scoreboard and execute-facing register; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= 32'd0;
      r_ex_valid  <= 1'b0;
      r_ex_pc     <= 32'd0;
      r_ex_instr  <= 32'd0;
      r_ex_op1    <= 32'd0;
      r_ex_op2    <= 32'd0;
      r_ex_rd     <= 5'd0;
      r_ex_rd_wen <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (flush) begin
        r_ex_valid <= 1'b0;
      end else if (w_capture) begin
        r_ex_valid <= 1'b1;
      end else if (ex_ready) begin
        r_ex_valid <= 1'b0;
      end else begin
        r_ex_valid <= r_ex_valid;
      end
      if (w_capture) begin
        r_ex_pc     <= if_pc;
        r_ex_instr  <= if_instr;
        r_ex_op1    <= w_src1;
        r_ex_op2    <= w_src2;
        r_ex_rd     <= w_rd;
        r_ex_rd_wen <= w_rd_wen;
      end else begin
        r_ex_pc     <= r_ex_pc;
        r_ex_instr  <= r_ex_instr;
        r_ex_op1    <= r_ex_op1;
        r_ex_op2    <= r_ex_op2;
        r_ex_rd     <= r_ex_rd;
        r_ex_rd_wen <= r_ex_rd_wen;
      end
    end
  end

  assign ex_valid  = r_ex_valid;
  assign ex_pc     = r_ex_pc;
  assign ex_instr  = r_ex_instr;
  assign ex_op1    = r_ex_op1;
  assign ex_op2    = r_ex_op2;
  assign ex_rd     = r_ex_rd;
  assign ex_rd_wen = r_ex_rd_wen;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Directed scenarios followed by randomized traffic. All of it is checked
// against a reference model that keeps a per-register "pending writer" flag
// array and the contents of the execute slot.
// Honours WB_BYPASS_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_instr;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic [4:0]  ex_rd;
  logic        ex_rd_wen;

  decode_stage dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rs1(rs1), .rs2(rs2), .op1(op1), .op2(op2),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen)
  );

  always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011,
                         JALR = 7'b1100111, ST = 7'b0100011, BR = 7'b1100011,
                         JAL = 7'b1101111, LUI = 7'b0110111, AUIPC = 7'b0010111;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit          m_pending [32];
  bit          m_ex_valid = 1'b0;
  logic [31:0] m_pc = 32'd0, m_instr = 32'd0, m_op1 = 32'd0, m_op2 = 32'd0;
  logic [4:0]  m_rd = 5'd0;
  bit          m_wen = 1'b0;
  // Values the model derives from the current inputs, used at the next edge
  bit          e_ready, e_wen;
  logic [31:0] e_src1, e_src2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void classify(input logic [6:0] opc, output bit u1, output bit u2, output bit w);
    u1 = 1'b0; u2 = 1'b0; w = 1'b0;
    case (opc)
      OP:              begin u1 = 1'b1; u2 = 1'b1; w = 1'b1; end
      OPI, LD, JALR:   begin u1 = 1'b1; w = 1'b1; end
      ST, BR:          begin u1 = 1'b1; u2 = 1'b1; end
      JAL, LUI, AUIPC: begin w = 1'b1; end
      default:         begin u1 = 1'b0; end
    endcase
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] opc, input logic [4:0] rd,
                                      input logic [4:0] a, input logic [4:0] b,
                                      input logic [6:0] top);
    return {top, b, a, 3'b000, rd, opc};
  endfunction

  // Value a source delivers: 0 if unused or x0, the writeback data if it is
  // bypassed, otherwise the register-file read data.
  function automatic logic [31:0] src_val(input bit used, input logic [4:0] idx, input logic [31:0] rf);
    if (!used || idx == 5'd0) return 32'd0;
    if (BYP && wb_en && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  function automatic bit src_stall(input bit used, input logic [4:0] idx);
    if (!used || idx == 5'd0) return 1'b0;
    if (BYP && wb_en && wb_rd == idx) return 1'b0;
    return m_pending[idx];
  endfunction

  // Mid-cycle: evaluate the model for the current inputs and check the
  // combinational outputs.
  task automatic settle();
    bit u1, u2, w;
    logic [4:0] a, b, d;
    #2;
    classify(if_instr[6:0], u1, u2, w);
    a = if_instr[19:15]; b = if_instr[24:20]; d = if_instr[11:7];
    e_wen   = w && (d != 5'd0);
    e_src1  = src_val(u1, a, op1);
    e_src2  = src_val(u2, b, op2);
    e_ready = !rst && !flush && (!m_ex_valid || ex_ready) &&
              !(src_stall(u1, a) || src_stall(u2, b) || (e_wen && m_pending[d]));
    chk("if_ready", 32'(if_ready), 32'(e_ready));
    chk("rs1", 32'(rs1), 32'(a));
    chk("rs2", 32'(rs2), 32'(b));
  endtask

  // Advance the model across one rising edge, then check the registered outputs.
  task automatic tick();
    bit cap;
    if (rst) begin
      foreach (m_pending[i]) m_pending[i] = 1'b0;
      m_ex_valid = 1'b0; m_pc = 32'd0; m_instr = 32'd0;
      m_op1 = 32'd0; m_op2 = 32'd0; m_rd = 5'd0; m_wen = 1'b0;
    end else begin
      cap = if_valid && e_ready;
      if (wb_en && wb_rd != 5'd0) m_pending[wb_rd] = 1'b0;
      if (flush && m_ex_valid && m_wen) m_pending[m_rd] = 1'b0;
      if (flush) m_ex_valid = 1'b0;
      else if (cap) m_ex_valid = 1'b1;
      else if (ex_ready) m_ex_valid = 1'b0;
      if (cap) begin
        m_pc = if_pc; m_instr = if_instr; m_op1 = e_src1; m_op2 = e_src2;
        m_rd = if_instr[11:7]; m_wen = e_wen;
        if (e_wen) m_pending[m_rd] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("ex_valid", 32'(ex_valid), 32'(m_ex_valid));
    chk("ex_pc", ex_pc, m_pc);
    chk("ex_instr", ex_instr, m_instr);
    chk("ex_op1", ex_op1, m_op1);
    chk("ex_op2", ex_op2, m_op2);
    chk("ex_rd", 32'(ex_rd), 32'(m_rd));
    chk("ex_rd_wen", 32'(ex_rd_wen), 32'(m_wen));
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    if_valid = v; if_instr = ins; if_pc = pc; op1 = a; op2 = b;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
    wb_en = en; wb_rd = rd; wb_data = d;
  endtask

  logic [6:0]  ops [10] = '{OP, OPI, LD, JALR, ST, BR, JAL, LUI, AUIPC, 7'b1111111};
  logic [31:0] add7;

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    set_wb(1'b0, 5'd0, 32'd0);

    // Reset state
    settle();
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    tick();
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_op1", ex_op1, 32'd0);
    rst = 1'b0;

    // ADD x3,x1,x2 with op1=5, op2=7
    drive(1'b1, enc(OP, 5'd3, 5'd1, 5'd2, 7'd0), 32'h100, 32'd5, 32'd7);
    settle();
    chk("add_ready", 32'(if_ready), 32'd1);
    tick();
    chk("add_ex_valid", 32'(ex_valid), 32'd1);
    chk("add_ex_op1", ex_op1, 32'd5);
    chk("add_ex_op2", ex_op2, 32'd7);
    chk("add_ex_rd", 32'(ex_rd), 32'd3);
    chk("add_ex_rd_wen", 32'(ex_rd_wen), 32'd1);

    // SUB x5,x3,x1 must wait on x3
    drive(1'b1, enc(OP, 5'd5, 5'd3, 5'd1, 7'h20), 32'h104, 32'd100, 32'd1);
    settle();
    chk("x3_busy_stall", 32'(if_ready), 32'd0);
    tick();
    set_wb(1'b1, 5'd3, 32'd9);
    settle();
`ifdef WB_BYPASS_EN
    chk("bypass_ready", 32'(if_ready), 32'd1);
    tick();
    chk("bypass_op1", ex_op1, 32'd9);
`else
    chk("nobypass_stall", 32'(if_ready), 32'd0);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    settle();
    chk("nobypass_ready", 32'(if_ready), 32'd1);
    tick();
    chk("nobypass_op1", ex_op1, 32'd100);
`endif
    chk("sub_ex_valid", 32'(ex_valid), 32'd1);
    set_wb(1'b0, 5'd0, 32'd0);

    // ADDI x4,x0,1: x0 reads as zero regardless of op1
    drive(1'b1, enc(OPI, 5'd4, 5'd0, 5'd1, 7'd0), 32'h108, 32'hDEADBEEF, 32'h1234);
    settle(); tick();
    chk("addi_x0_op1", ex_op1, 32'd0);
    chk("addi_wen", 32'(ex_rd_wen), 32'd1);
    // SW x0,9(x0): imm bits sit in the rd field but nothing becomes busy
    drive(1'b1, enc(ST, 5'd9, 5'd0, 5'd0, 7'd0), 32'h10c, 32'hAAAA, 32'hBBBB);
    settle(); tick();
    chk("sw_wen", 32'(ex_rd_wen), 32'd0);
    chk("sw_op2", ex_op2, 32'd0);
    drive(1'b1, enc(OPI, 5'd9, 5'd1, 5'd1, 7'd0), 32'h110, 32'd1, 32'd0);
    settle();
    chk("sw_no_busy", 32'(if_ready), 32'd1);
    tick();
    // LUI x0: its register fields are immediate bits, so x5 (busy) is ignored
    drive(1'b1, enc(LUI, 5'd0, 5'd3, 5'd5, 7'h12), 32'h114, 32'd1, 32'd2);
    settle();
    chk("lui_ready", 32'(if_ready), 32'd1);
    tick();
    chk("lui_wen", 32'(ex_rd_wen), 32'd0);
    chk("lui_op1", ex_op1, 32'd0);

    // Backpressure for three cycles, then flush
    add7 = enc(OP, 5'd7, 5'd1, 5'd2, 7'd0);
    drive(1'b1, add7, 32'h118, 32'd11, 32'd22);
    settle(); tick();
    ex_ready = 1'b0;
    drive(1'b1, enc(OP, 5'd10, 5'd1, 5'd2, 7'd0), 32'h11c, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_if_ready", 32'(if_ready), 32'd0);
      tick();
      chk("bp_ex_instr", ex_instr, add7);
      chk("bp_ex_op2", ex_op2, 32'd22);
      chk("bp_ex_valid", 32'(ex_valid), 32'd1);
    end
    flush = 1'b1; ex_ready = 1'b1;
    settle();
    chk("flush_if_ready", 32'(if_ready), 32'd0);
    tick();
    chk("flush_ex_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0;
    drive(1'b1, enc(OP, 5'd8, 5'd7, 5'd0, 7'd0), 32'h120, 32'd3, 32'd4);
    settle();
    chk("flush_freed_x7", 32'(if_ready), 32'd1);
    tick();

    // WAW on x6, same-cycle set/clear, reset during a stall
    drive(1'b1, enc(OPI, 5'd6, 5'd1, 5'd1, 7'd0), 32'h124, 32'd1, 32'd0);
    settle(); tick();
    settle();
    chk("waw_stall", 32'(if_ready), 32'd0);
    tick();
    set_wb(1'b1, 5'd6, 32'h55);
    settle();
    chk("waw_stall_wb", 32'(if_ready), 32'd0);
    tick();
    settle();
    chk("waw_released", 32'(if_ready), 32'd1);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    settle();
    chk("set_wins", 32'(if_ready), 32'd0);
    tick();
    rst = 1'b1;
    settle();
    chk("rst_mid_ready", 32'(if_ready), 32'd0);
    tick();
    chk("rst_mid_ex_valid", 32'(ex_valid), 32'd0);
    rst = 1'b0;
    settle();
    chk("no_stale_busy", 32'(if_ready), 32'd1);
    tick();
    chk("post_rst_ex_valid", 32'(ex_valid), 32'd1);

    // Randomized traffic against the model
    rst = 1'b1; drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0); set_wb(1'b0, 5'd0, 32'd0);
    settle(); tick();
    for (int k = 0; k < 800; k++) begin
      logic [31:0] ri;
      ri = $urandom;
      ri[6:0]   = ops[$urandom_range(0, 9)];
      ri[11:7]  = 5'($urandom_range(0, 7));
      ri[19:15] = 5'($urandom_range(0, 7));
      ri[24:20] = 5'($urandom_range(0, 7));
      rst      = ($urandom_range(0, 99) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 3) != 0), ri, $urandom, $urandom, $urandom);
      set_wb(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom);
      settle();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
